// File: rtl/output_handler_pkg.sv
// Shared definitions for the output handler: port map, FSM encodings,
// captured request layout and the PWM compare helper.
package output_handler_pkg;

    // Output port map
    localparam logic [2:0] OUT_PORT_LEDS    = 3'd0;
    localparam logic [2:0] OUT_PORT_GPIO_P6 = 3'd1;
    localparam logic [2:0] OUT_PORT_GPIO_P7 = 3'd2;
    localparam logic [2:0] OUT_PORT_GPIO_P8 = 3'd3;
    localparam logic [2:0] OUT_PORT_GPIO_P9 = 3'd4;
    localparam logic [2:0] OUT_PORT_PULSE   = 3'd5;
    localparam logic [2:0] OUT_PORT_CLEAR   = 3'd6;
    localparam logic [2:0] OUT_PORT_PWM     = 3'd7;

    localparam int unsigned NUM_USER_OUTPUTS = 40;

    // Handshake FSM encodings
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_APPLY = 1'b1;

    // Request captured at the handshake edge, consumed in APPLY
    typedef struct packed {
        logic [2:0] port;
        logic [7:0] data;
    } out_req_t;

    // PWM gate: full duty is always on, otherwise on while counter < duty
    function automatic logic pwm_on(input logic [7:0] duty, input logic [7:0] cnt);
        return (duty == 8'hFF) || (cnt < duty);
    endfunction

endpackage

// File: rtl/output_handler_led_pwm.sv
// LED PWM gate, used only when OUTPUT_PWM_EN is defined.
// duty and composite are the values that will be in effect after the
// coming edge, so the registered leds track them without a cycle of lag.
module led_pwm
    import output_handler_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] duty,
    input  logic [7:0] composite,
    output logic [7:0] leds
);

    logic [7:0] r_pwm_cnt;
    logic [7:0] r_leds;
    logic [7:0] w_pwm_cnt_nxt;

    assign w_pwm_cnt_nxt = r_pwm_cnt + 8'd1;

    // Free-running PWM counter and gated, registered LED outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm_cnt <= '0;
            r_leds    <= '0;
        end else begin
            r_pwm_cnt <= w_pwm_cnt_nxt;
            r_leds    <= composite & {8{pwm_on(duty, w_pwm_cnt_nxt)}};
        end
    end

    assign leds = r_leds;

endmodule

// File: rtl/output_handler.sv
// Output handler: accepts processor OUTPUT writes through a valid/ready
// handshake and drives the LED, pulse and GPIO output registers.
// Optional feature: define OUTPUT_PWM_EN to add LED PWM dimming on port 7.
module output_handler
    import output_handler_pkg::*;
#(
    parameter int unsigned PULSE_CYCLES = 50000,
    parameter int unsigned PULSE_W      = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       out_valid,
    output logic       out_ready,
    input  logic [2:0] out_port,
    input  logic [7:0] out_data,
    output logic [7:0] leds,
    output logic [7:0] gpio_p6,
    output logic [7:0] gpio_p7,
    output logic [7:0] gpio_p8,
    output logic [7:0] gpio_p9
);

    localparam logic [PULSE_W-1:0] C_PULSE_LOAD = PULSE_W'(PULSE_CYCLES - 1);

    logic [0:0]         r_state;
    logic               r_ready;
    out_req_t           r_req;

    logic [7:0]         r_led_reg;
    logic [7:0]         r_gpio_p6;
    logic [7:0]         r_gpio_p7;
    logic [7:0]         r_gpio_p8;
    logic [7:0]         r_gpio_p9;
    logic [7:0]         r_pulse_mask;
    logic [PULSE_W-1:0] r_pulse_cnt;

    logic               w_apply;
    logic [7:0]         w_led_nxt;
    logic [7:0]         w_gpio_p6_nxt;
    logic [7:0]         w_gpio_p7_nxt;
    logic [7:0]         w_gpio_p8_nxt;
    logic [7:0]         w_gpio_p9_nxt;
    logic [7:0]         w_mask_nxt;
    logic [PULSE_W-1:0] w_cnt_nxt;
    logic [7:0]         w_comp_nxt;

    assign w_apply = (r_state == ST_APPLY);

    // Handshake FSM: capture in IDLE, apply for one cycle, back to IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
            r_req   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (out_valid && r_ready) begin
                        r_req.port <= out_port;
                        r_req.data <= out_data;
                        r_state    <= ST_APPLY;
                        r_ready    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    // Next-state of the output registers: pulse timer first, then any write on top.
    // The counter holds remaining pulse cycles minus one; the mask drops on the
    // edge seen with counter == 0, so a pulse lasts exactly PULSE_CYCLES cycles
    // and a pulse write on that same edge overrides the drop.
    always_comb begin
        w_led_nxt     = r_led_reg;
        w_gpio_p6_nxt = r_gpio_p6;
        w_gpio_p7_nxt = r_gpio_p7;
        w_gpio_p8_nxt = r_gpio_p8;
        w_gpio_p9_nxt = r_gpio_p9;
        w_mask_nxt    = r_pulse_mask;
        w_cnt_nxt     = r_pulse_cnt;

        if (r_pulse_cnt != '0) begin
            w_cnt_nxt = r_pulse_cnt - 1'b1;
        end else begin
            w_mask_nxt = '0;
        end

        if (w_apply) begin
            case (r_req.port)
                OUT_PORT_LEDS:    w_led_nxt     = r_req.data;
                OUT_PORT_GPIO_P6: w_gpio_p6_nxt = r_req.data;
                OUT_PORT_GPIO_P7: w_gpio_p7_nxt = r_req.data;
                OUT_PORT_GPIO_P8: w_gpio_p8_nxt = r_req.data;
                OUT_PORT_GPIO_P9: w_gpio_p9_nxt = r_req.data;
                OUT_PORT_PULSE: begin
                    w_mask_nxt = r_pulse_mask | r_req.data;
                    w_cnt_nxt  = C_PULSE_LOAD;
                end
                OUT_PORT_CLEAR: begin
                    w_led_nxt     = '0;
                    w_gpio_p6_nxt = '0;
                    w_gpio_p7_nxt = '0;
                    w_gpio_p8_nxt = '0;
                    w_gpio_p9_nxt = '0;
                    w_mask_nxt    = '0;
                    w_cnt_nxt     = '0;
                end
                default: ;
            endcase
        end
    end

    assign w_comp_nxt = w_led_nxt | w_mask_nxt;

    // Output and pulse state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_led_reg    <= '0;
            r_gpio_p6    <= '0;
            r_gpio_p7    <= '0;
            r_gpio_p8    <= '0;
            r_gpio_p9    <= '0;
            r_pulse_mask <= '0;
            r_pulse_cnt  <= '0;
        end else begin
            r_led_reg    <= w_led_nxt;
            r_gpio_p6    <= w_gpio_p6_nxt;
            r_gpio_p7    <= w_gpio_p7_nxt;
            r_gpio_p8    <= w_gpio_p8_nxt;
            r_gpio_p9    <= w_gpio_p9_nxt;
            r_pulse_mask <= w_mask_nxt;
            r_pulse_cnt  <= w_cnt_nxt;
        end
    end

`ifdef OUTPUT_PWM_EN
    logic [7:0] r_duty;
    logic [7:0] w_duty_nxt;

    // Duty register next-state: loaded by a port 7 write
    always_comb begin
        w_duty_nxt = r_duty;
        if (w_apply && (r_req.port == OUT_PORT_PWM)) begin
            w_duty_nxt = r_req.data;
        end
    end

    // Duty register, full brightness out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_duty <= 8'hFF;
        end else begin
            r_duty <= w_duty_nxt;
        end
    end

    led_pwm u_led_pwm (
        .clk       (clk),
        .rst_n     (rst_n),
        .duty      (w_duty_nxt),
        .composite (w_comp_nxt),
        .leds      (leds)
    );
`else
    logic [7:0] r_leds;

    // Registered LED composite so leds comes straight from a flop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_leds <= '0;
        end else begin
            r_leds <= w_comp_nxt;
        end
    end

    assign leds = r_leds;
`endif

    assign out_ready = r_ready;
    assign gpio_p6   = r_gpio_p6;
    assign gpio_p7   = r_gpio_p7;
    assign gpio_p8   = r_gpio_p8;
    assign gpio_p9   = r_gpio_p9;

endmodule

// File: tb/tb_output_handler.sv
// Directed self-checking bench for output_handler (PULSE_CYCLES = 4).
// Follows OUTPUT_PWM_EN to pick the expected PWM behaviour.
module tb_output_handler;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       out_valid = 1'b0;
    logic [2:0] out_port  = '0;
    logic [7:0] out_data  = '0;
    logic       out_ready;
    logic [7:0] leds;
    logic [7:0] gpio_p6;
    logic [7:0] gpio_p7;
    logic [7:0] gpio_p8;
    logic [7:0] gpio_p9;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    output_handler #(
        .PULSE_CYCLES (4),
        .PULSE_W      (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_port  (out_port),
        .out_data  (out_data),
        .leds      (leds),
        .gpio_p6   (gpio_p6),
        .gpio_p7   (gpio_p7),
        .gpio_p8   (gpio_p8),
        .gpio_p9   (gpio_p9)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge with the FSM idle; returns at the negedge after the
    // handshake edge N, i.e. while the DUT is in APPLY.
    task automatic send(input logic [2:0] p, input logic [7:0] d);
        int unsigned k = 0;
        while (out_ready !== 1'b1 && k < 8) begin
            @(negedge clk);
            k++;
        end
        check("send_ready", out_ready, 1'b1);
        out_valid = 1'b1;
        out_port  = p;
        out_data  = d;
        @(posedge clk);
        @(negedge clk);
        out_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int unsigned on_cnt;

        // Reset state
        step(2);
        check("rst_ready", out_ready, 1'b1);
        check("rst_leds", leds, 8'h00);
        check("rst_p6", gpio_p6, 8'h00);
        check("rst_p7", gpio_p7, 8'h00);
        check("rst_p8", gpio_p8, 8'h00);
        check("rst_p9", gpio_p9, 8'h00);
        rst_n = 1'b1;
        step(1);

        // Preload LED and GPIO registers
        send(3'd0, 8'h01); step(1);
        send(3'd1, 8'h11); step(1);
        send(3'd3, 8'h33); step(1);
        send(3'd4, 8'h44); step(1);
        check("pre_leds", leds, 8'h01);
        check("pre_p6", gpio_p6, 8'h11);

        // GPIO write to port 2: visible after N+1, ready low for one cycle
        send(3'd2, 8'hA5);
        check("gpio_ready_low", out_ready, 1'b0);
        check("gpio_p7_not_yet", gpio_p7, 8'h00);
        step(1);
        check("gpio_ready_back", out_ready, 1'b1);
        check("gpio_p7", gpio_p7, 8'hA5);
        check("gpio_p6_kept", gpio_p6, 8'h11);
        check("gpio_p8_kept", gpio_p8, 8'h33);
        check("gpio_p9_kept", gpio_p9, 8'h44);
        check("gpio_leds_kept", leds, 8'h01);

        // Valid held high across APPLY: second transaction at next IDLE edge
        out_valid = 1'b1; out_port = 3'd1; out_data = 8'h5A;
        @(posedge clk); @(negedge clk);
        check("b2b_ready_low", out_ready, 1'b0);
        out_port = 3'd3; out_data = 8'hC3;
        step(1);
        check("b2b_p6", gpio_p6, 8'h5A);
        check("b2b_ready_idle", out_ready, 1'b1);
        step(1);
        out_valid = 1'b0;
        check("b2b_ready_low2", out_ready, 1'b0);
        check("b2b_p8_not_yet", gpio_p8, 8'h33);
        step(1);
        check("b2b_p8", gpio_p8, 8'hC3);

        // Pulse: 0x80 on top of LED 0x01 for exactly 4 cycles
        send(3'd5, 8'h80);
        check("pulse_not_yet", leds, 8'h01);
        for (int i = 0; i < 4; i++) begin
            step(1);
            check("pulse_on", leds, 8'h81);
        end
        step(1);
        check("pulse_off", leds, 8'h01);
        step(1);
        check("pulse_off2", leds, 8'h01);

        // Retrigger on the expiry edge: mask ORs, counter reloads
        send(3'd5, 8'h80);
        step(3);
        send(3'd5, 8'h40);
        check("retrig_first_on", leds, 8'h81);
        for (int i = 0; i < 4; i++) begin
            step(1);
            check("retrig_on", leds, 8'hC1);
        end
        step(1);
        check("retrig_off", leds, 8'h01);

        // Clear-all with a pulse active
        send(3'd5, 8'h80);
        step(1);
        check("clr_pulse_active", leds, 8'h81);
        send(3'd6, 8'h5F);
        check("clr_not_yet", leds, 8'h81);
        step(1);
        check("clr_leds", leds, 8'h00);
        check("clr_p6", gpio_p6, 8'h00);
        check("clr_p7", gpio_p7, 8'h00);
        check("clr_p8", gpio_p8, 8'h00);
        check("clr_p9", gpio_p9, 8'h00);
        step(4);
        check("clr_leds_stay", leds, 8'h00);

        // Reset asserted during APPLY of port 0, data 0xFF
        send(3'd0, 8'hFF);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", out_ready, 1'b1);
        check("mid_rst_leds", leds, 8'h00);
        step(2);
        rst_n = 1'b1;
        step(2);
        check("post_rst_leds", leds, 8'h00);
        check("post_rst_ready", out_ready, 1'b1);

        // PWM: LED register 0xFF, port 7 write 0x40
        send(3'd0, 8'hFF); step(1);
        check("pwm_full_leds", leds, 8'hFF);
        send(3'd7, 8'h40); step(1);
        check("pwm_p6_kept", gpio_p6, 8'h00);
        on_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            if (leds == 8'hFF) on_cnt++;
            step(1);
        end
`ifdef OUTPUT_PWM_EN
        check("pwm_on_cycles", on_cnt, 64);
`else
        check("pwm_on_cycles", on_cnt, 256);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
